// File: rtl/instruction_fetch.sv
// instruction_fetch: RISC-V fetch stage driving a word-addressed instruction memory,
// with an IF/ID register, stall, redirect/flush and halt on EBREAK.
module instruction_fetch #(
  parameter int BITS = 32,
  parameter int ADDR_W = 5,
  parameter logic [BITS-1:0] RESET_PC = '0,
  parameter logic [BITS-1:0] EBREAK = 32'h0010_0073
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [BITS-1:0]   redirect_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [BITS-1:0]   imem_data,
  output logic              if_valid,
  output logic [BITS-1:0]   if_pc,
  output logic [BITS-1:0]   if_pc_plus4,
  output logic [BITS-1:0]   if_instr,
  output logic              halted
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2;
  logic [1:0] state;
  logic [BITS-1:0] pc, target;
  logic fetch, brk;
  assign target = redirect_target & ~BITS'(3);
  assign imem_addr = pc[ADDR_W+1:2];
  assign halted = state == HALTED;
  assign fetch = state == RUN && !redirect && !stall;
  assign brk = imem_data == EBREAK;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      state <= BOOT;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_pc_plus4 <= '0;
      if_instr <= '0;
    end else begin
      if (redirect) pc <= target;
      else if (fetch && !brk) pc <= pc + BITS'(4);
      state <= (state == BOOT || redirect) ? RUN : (fetch && brk) ? HALTED : state;
      if (state == BOOT || redirect) if_valid <= 1'b0;
      else if (!stall) if_valid <= state == RUN;
      if (fetch) begin
        if_instr <= imem_data;
        if_pc <= pc;
        if_pc_plus4 <= pc + BITS'(4);
      end
    end
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the RISC-V datapath, directly upstream of the word-addressed instruction memory (5-bit word address in, 32-bit instruction out, combinational read).
- Holds the byte-addressed program counter and drives the memory word address. Captures the returned instruction into an IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, and halt on EBREAK.

Parameters:
- BITS, 32, instruction and PC width
- ADDR_W, 5, instruction-memory word-address width
- RESET_PC, 32'h0000_0000, PC value loaded at reset (byte address, word aligned)
- EBREAK, 32'h0010_0073, encoding that halts fetch

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID register
- redirect  input  1  taken branch/jump from execute: load new PC, flush IF/ID
- redirect_target  input  BITS  byte target of the redirect
- imem_addr  output  ADDR_W  word address to instruction memory
- imem_data  input  BITS  instruction returned by memory (same cycle)
- if_valid  output  1  IF/ID register holds a real instruction
- if_pc  output  BITS  byte PC of the instruction in IF/ID
- if_pc_plus4  output  BITS  if_pc + 4
- if_instr  output  BITS  instruction in IF/ID
- halted  output  1  fetch stopped after EBREAK

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=BOOT, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, halted=0.
- imem_addr = pc[ADDR_W+1:2], combinational. Byte addresses wrap modulo 2^ADDR_W words: pc=0x80 fetches word 0. The pc register itself is full BITS wide and wraps at 2^BITS.
- State machine, registered, 3 states:
  - BOOT: one cycle after reset release. if_valid<=0, pc unchanged. Next state is RUN. A redirect in BOOT still loads pc.
  - RUN: normal fetch. Per rising edge, first matching rule wins:
    1. redirect=1: pc<={redirect_target[BITS-1:2],2'b00}. Low two bits are silently cleared. if_valid<=0 (flush). Stall is ignored.
    2. stall=1: pc, if_valid, if_pc, if_instr, if_pc_plus4 all hold.
    3. Otherwise: if_instr<=imem_data, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
    - If rule 3 fires with imem_data==EBREAK: the EBREAK is latched valid, pc holds (not incremented), next state is HALTED.
  - HALTED: halted=1. If_valid<=0 on the next non-stalled edge; if stall=1, IF/ID holds. pc holds.
    - redirect=1 loads pc as in rule 1, clears halted, and returns to RUN.
- Latency: the instruction at pc appears in if_instr/if_valid one clock after it is addressed. Throughput is 1 instruction per cycle when unstalled.
- Redirect while an EBREAK is being fetched: redirect wins. The EBREAK is not latched and the state stays RUN.
- Reset asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- if_pc_plus4 wraps at 2^BITS: 0xFFFF_FFFC+4 = 0.

Test Plan:
- Reset release, memory words 1..5 = 0x01002103, 0x00012423, 0x000100B3, 0x402001B3, 0xFEA18213 -> BOOT cycle has if_valid=0. The first valid entry is if_pc=0 with instr=word 0. The next entries are if_pc=4 instr=0x01002103, then if_pc=8 instr=0x00012423, one per cycle. imem_addr steps 0,1,2,...
- Stall held 3 cycles while if_pc=0x0C -> if_pc, if_instr and imem_addr are frozen for 3 cycles. The next cycle delivers if_pc=0x10 instr=0x402001B3 with no duplicate and no skipped instruction.
- Redirect with target=0x20 while pc=0x1C -> the next cycle has if_valid=0. The following cycle has if_pc=0x20, imem_addr=8, and instr equal to memory word 8 (0x00221663).
- Redirect and stall asserted together with target=0x2F -> redirect wins. pc=0x2C, imem_addr=11, if_valid=0.
- EBREAK (0x00100073) at word 3 -> if_instr=0x00100073 valid once. Then halted=1, if_valid=0 and imem_addr held at 3 for 10+ cycles. A redirect to 0x04 clears halted and fetch resumes at word 1.
- Reset pulsed asynchronously between clock edges while if_valid=1 and pc=0x40 -> outputs go to reset values immediately (if_valid=0, imem_addr=0). One BOOT cycle follows release.
